// File: rtl/diff_pe_weight_loader.sv
// Fetches 3*3 / 5*5 kernels from the weight buffer and hands them to the PE.
// Define DIFF_WT_LOADER_STALL_CNT_EN to add the stall_cnt output.
package diff_pe_pkg;
  localparam int PE_BW = 8;

  typedef struct packed {
    logic [8:0][PE_BW-1:0] a9;
    logic [5:0][PE_BW-1:0] b6;
    logic [5:0][PE_BW-1:0] c6;
    logic [3:0][PE_BW-1:0] d4;
  } PE_weight_t;

  typedef enum logic {
    A_MODE = 1'b0,
    E_MODE = 1'b1
  } PE_weight_mode_t;
endpackage

module diff_pe_weight_loader
  import diff_pe_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CONF_WT_BUF_DEPTH = 512,
  localparam int AW = $clog2(CONF_WT_BUF_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   kernel_mode,
  input  logic [AW-1:0]          base_addr,
  input  logic [7:0]             num_kernels,
  output logic                   wt_rd_en,
  output logic [AW-1:0]          wt_rd_addr,
  input  logic [8*BIT_WIDTH-1:0] wt_rd_data,
  output PE_weight_t             wt_out,
  output PE_weight_mode_t        wt_mode,
  output logic                   wt_valid,
  input  logic                   wt_ready,
  output logic                   busy,
  output logic                   done
`ifdef DIFF_WT_LOADER_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OUT,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_nx;
  logic            rd_en_q;
  logic [1:0]      cnt_q;
  logic            rd_d1_q;
  logic [1:0]      widx_q;
  logic            mode5_q;
  PE_weight_mode_t mode_q;
  logic [7:0]      kleft_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      last_w;
  logic [5:0]      lim;
  logic [5:0]      sidx;

  logic [24:0][BIT_WIDTH-1:0] kb_q;
  logic [24:0][BIT_WIDTH-1:0] kb_d;

  assign last_w = mode5_q ? 2'd3 : 2'd1;
  assign lim    = mode5_q ? 6'd25 : 6'd9;

  assign addr_nx = (addr_q == AW'(CONF_WT_BUF_DEPTH - 1)) ?
                   '0 : addr_q + 1'b1;

  // Word widx_q lands at stream bytes 8*widx_q .. 8*widx_q+7
  always_comb begin
    kb_d = kb_q;
    sidx = '0;
    if (rd_d1_q) begin
      for (int j = 0; j < 8; j++) begin
        sidx = {1'b0, widx_q, 3'b000} + 6'(j);
        if (sidx < lim)
          kb_d[sidx[4:0]] = wt_rd_data[j*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      cnt_q   <= '0;
      rd_d1_q <= 1'b0;
      widx_q  <= '0;
      mode5_q <= 1'b0;
      mode_q  <= A_MODE;
      kleft_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kb_q    <= '0;
    end else begin
      rd_d1_q <= rd_en_q;
      widx_q  <= cnt_q;
      kb_q    <= kb_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode5_q <= kernel_mode;
            mode_q  <= kernel_mode ? A_MODE : E_MODE;
            kleft_q <= num_kernels;
            addr_q  <= base_addr;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            kb_q    <= '0;
            if (num_kernels == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          addr_q <= addr_nx;
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == last_w) begin
            rd_en_q <= 1'b0;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          state_q <= S_OUT;
          valid_q <= 1'b1;
        end
        S_OUT: begin
          if (wt_ready) begin
            valid_q <= 1'b0;
            kleft_q <= kleft_q - 8'd1;
            if (kleft_q == 8'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wt_rd_en   = rd_en_q;
  assign wt_rd_addr = addr_q;
  assign wt_valid   = valid_q;
  assign wt_mode    = mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wt_out     = {kb_q[8:0], kb_q[14:9], kb_q[20:15], kb_q[24:21]};

`ifdef DIFF_WT_LOADER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (state_q == S_IDLE && start)
      stall_q <= '0;
    else if (valid_q && !wt_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_diff_pe_weight_loader.sv
// Directed bench for diff_pe_weight_loader.
// Cycle 0 is the cycle in which start is high.
module tb_diff_pe_weight_loader;
  import diff_pe_pkg::*;

  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            kernel_mode;
  logic [AW-1:0]   base_addr;
  logic [7:0]      num_kernels;
  logic            wt_rd_en;
  logic [AW-1:0]   wt_rd_addr;
  logic [63:0]     wt_rd_data;
  PE_weight_t      wt_out;
  PE_weight_mode_t wt_mode;
  logic            wt_valid;
  logic            wt_ready;
  logic            busy;
  logic            done;
`ifdef DIFF_WT_LOADER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  diff_pe_weight_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kernel_mode (kernel_mode),
    .base_addr   (base_addr),
    .num_kernels (num_kernels),
    .wt_rd_en    (wt_rd_en),
    .wt_rd_addr  (wt_rd_addr),
    .wt_rd_data  (wt_rd_data),
    .wt_out      (wt_out),
    .wt_mode     (wt_mode),
    .wt_valid    (wt_valid),
    .wt_ready    (wt_ready),
    .busy        (busy),
    .done        (done)
`ifdef DIFF_WT_LOADER_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [512];

  always @(posedge clk)
    wt_rd_data <= wt_rd_en ? mem[wt_rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;

  int              rd_addr_q[$];
  int              rd_cyc_q[$];
  int              rise_q[$];
  int              hs_cyc_q[$];
  PE_weight_t      hs_out_q[$];
  PE_weight_mode_t hs_mode_q[$];
  int              ndone = 0;
  int              done_cyc = -1;
  int              stab_err = 0;
  logic            pv = 1'b0;
  logic            pr = 1'b0;
  PE_weight_t      po = '0;
  PE_weight_mode_t pm = A_MODE;

  always @(negedge clk) begin
    if (wt_rd_en) begin
      rd_addr_q.push_back(int'(wt_rd_addr));
      rd_cyc_q.push_back(cyc - t0);
    end
    if (wt_valid && !pv) rise_q.push_back(cyc - t0);
    if (wt_valid && pv && !pr && (wt_out != po || wt_mode != pm))
      stab_err <= stab_err + 1;
    if (wt_valid && wt_ready) begin
      hs_cyc_q.push_back(cyc - t0);
      hs_out_q.push_back(wt_out);
      hs_mode_q.push_back(wt_mode);
    end
    if (done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc - t0;
    end
    pv <= wt_valid;
    pr <= wt_ready;
    po <= wt_out;
    pm <= wt_mode;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 8; j++)
        mem[(base + k) % 512][8*j +: 8] = 8'(8*k + j);
  endtask

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    rise_q.delete();
    hs_cyc_q.delete();
    hs_out_q.delete();
    hs_mode_q.delete();
  endtask

  function automatic PE_weight_t exp_k(input bit m5, input int k);
    PE_weight_t w;
    int o;
    w = '0;
    o = m5 ? 32*k : 16*k;
    for (int i = 0; i < 9; i++) w.a9[i] = 8'(o + i);
    if (m5) begin
      for (int i = 0; i < 6; i++) begin
        w.b6[i] = 8'(o + 9 + i);
        w.c6[i] = 8'(o + 15 + i);
      end
      for (int i = 0; i < 4; i++) w.d4[i] = 8'(o + 21 + i);
    end
    return w;
  endfunction

  task automatic pulse_start(input bit m5, input int base, input int num);
    @(posedge clk); #1;
    start       = 1'b1;
    kernel_mode = m5;
    base_addr   = AW'(base);
    num_kernels = 8'(num);
    t0          = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic goto_cycle(input int n);
    while ((cyc - t0) < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int base_n, input int budget);
    int i;
    i = 0;
    while (ndone == base_n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk("done_seen", 256'(ndone != base_n), 256'd1);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {wt_out, wt_mode, wt_valid, wt_rd_en, wt_rd_addr, busy, done},
        256'd0);
  endtask

  int nd;
  int sb;
  int i;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    kernel_mode = 1'b0;
    base_addr   = '0;
    num_kernels = '0;
    wt_ready    = 1'b1;
    #3;
    chk_outs_zero("reset_outs");
`ifdef DIFF_WT_LOADER_STALL_CNT_EN
    chk("reset_stall", stall_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 3*3, one kernel at 0x010
    fill('h010);
    clear_mon();
    nd = ndone;
    pulse_start(1'b0, 'h010, 1);
    wait_done(nd, 40);
    chk("t1_nrd", rd_addr_q.size(), 2);
    chk("t1_a0", rd_addr_q[0], 'h010);
    chk("t1_a1", rd_addr_q[1], 'h011);
    chk("t1_c0", rd_cyc_q[0], 1);
    chk("t1_c1", rd_cyc_q[1], 2);
    chk("t1_rise", rise_q[0], 4);
    chk("t1_out", hs_out_q[0], exp_k(1'b0, 0));
    chk("t1_mode", hs_mode_q[0], E_MODE);
    chk("t1_done", done_cyc, 5);
    @(negedge clk);
    chk("t1_busy_low", busy, 1'b0);

    // 5*5, two kernels, address wrap
    fill('h1FE);
    clear_mon();
    nd = ndone;
    pulse_start(1'b1, 'h1FE, 2);
    wait_done(nd, 60);
    chk("t2_nrd", rd_addr_q.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_a%0d", k), rd_addr_q[k], ('h1FE + k) % 512);
    chk("t2_c4", rd_cyc_q[4], 7);
    chk("t2_rise0", rise_q[0], 6);
    chk("t2_rise1", rise_q[1], 12);
    chk("t2_out0", hs_out_q[0], exp_k(1'b1, 0));
    chk("t2_d4", hs_out_q[0].d4, {8'd24, 8'd23, 8'd22, 8'd21});
    chk("t2_out1", hs_out_q[1], exp_k(1'b1, 1));
    chk("t2_mode", hs_mode_q[0], A_MODE);
    chk("t2_done", done_cyc, 13);

    // Backpressure: ready low for 5 cycles
    fill('h040);
    clear_mon();
    nd = ndone;
    sb = stab_err;
    wt_ready = 1'b0;
    pulse_start(1'b0, 'h040, 2);
    i = 0;
    while (!wt_valid && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("t3_valid_seen", wt_valid, 1'b1);
    repeat (5) @(posedge clk);
    #1 wt_ready = 1'b1;
    wait_done(nd, 60);
    chk("t3_rise", rise_q[0], 4);
    chk("t3_hs", hs_cyc_q[0], 9);
    chk("t3_c1", rd_cyc_q[1], 2);
    chk("t3_c2", rd_cyc_q[2], 10);
    chk("t3_a2", rd_addr_q[2], 'h042);
    chk("t3_stable", stab_err - sb, 0);
    chk("t3_out0", hs_out_q[0], exp_k(1'b0, 0));
    chk("t3_out1", hs_out_q[1], exp_k(1'b0, 1));
    chk("t3_done", done_cyc, 14);
`ifdef DIFF_WT_LOADER_STALL_CNT_EN
    chk("t3_stall", stall_cnt, 5);
`endif

    // num_kernels = 0
    clear_mon();
    pulse_start(1'b0, 'h001, 0);
    @(negedge clk);
    chk("t4_done", done, 1'b1);
    chk("t4_busy1", busy, 1'b1);
    @(negedge clk);
    chk("t4_busy2", busy, 1'b0);
    chk("t4_nrd", rd_addr_q.size(), 0);

    // Reset during the third read of a 5*5 load
    fill('h080);
    clear_mon();
    nd = ndone;
    pulse_start(1'b1, 'h080, 1);
    repeat (3) @(negedge clk);
    chk("t5_rd3_en", wt_rd_en, 1'b1);
    chk("t5_rd3_addr", wt_rd_addr, 'h082);
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("t5_rst_outs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t5_no_done", ndone - nd, 0);
    clear_mon();
    nd = ndone;
    pulse_start(1'b1, 'h080, 1);
    wait_done(nd, 40);
    chk("t5_nrd", rd_addr_q.size(), 4);
    chk("t5_a0", rd_addr_q[0], 'h080);
    chk("t5_c0", rd_cyc_q[0], 1);
    chk("t5_rise", rise_q[0], 6);
    chk("t5_out", hs_out_q[0], exp_k(1'b1, 0));
    chk("t5_done", done_cyc, 7);

    // start while busy and in the done cycle is ignored
    fill('h100);
    clear_mon();
    nd = ndone;
    pulse_start(1'b0, 'h100, 2);
    @(posedge clk); #1;
    start       = 1'b1;
    kernel_mode = 1'b1;
    base_addr   = 'h0AA;
    num_kernels = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    goto_cycle(9);
    chk("t6_done_cyc", done, 1'b1);
    start     = 1'b1;
    base_addr = 'h0AA;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_nrd", rd_addr_q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t6_a%0d", k), rd_addr_q[k], 'h100 + k);
    chk("t6_c2", rd_cyc_q[2], 5);
    chk("t6_mode", hs_mode_q[1], E_MODE);
    chk("t6_out1", hs_out_q[1], exp_k(1'b0, 1));
    chk("t6_ndone", ndone - nd, 1);
    chk("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
